// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB stage: destination select, result select and load size.
// Pure constants, no logic.
package wb_pkg;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_RA  = 2'b10;

    localparam logic [1:0] RWD_ALU  = 2'b00;
    localparam logic [1:0] RWD_MEM  = 2'b01;
    localparam logic [1:0] RWD_LINK = 2'b10;

    localparam logic [1:0] LD_B     = 2'b00;
    localparam logic [1:0] LD_H     = 2'b01;
    localparam logic [1:0] LD_W     = 2'b10;

    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_load_extract.sv
// Sub-word load extraction from an aligned big-endian DMEM word (byte/half/word, sign or zero extend).
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Misaligned half/word accesses simply ignore the low offset bits.
module wb_load_extract
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] res
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Offset 0 addresses the most significant byte.
    always_comb begin
        lane_b = word[DATA_W-1 -: 8];
        case (offset)
            2'd1:    lane_b = word[DATA_W-9  -: 8];
            2'd2:    lane_b = word[DATA_W-17 -: 8];
            2'd3:    lane_b = word[DATA_W-25 -: 8];
            default: lane_b = word[DATA_W-1  -: 8];
        endcase
        lane_h = offset[1] ? word[DATA_W-17 -: 16] : word[DATA_W-1 -: 16];
    end

    always_comb begin
        res = word;
        case (size)
            LD_B:    res = {{(DATA_W-8){~uns & lane_b[7]}}, lane_b};
            LD_H:    res = {{(DATA_W-16){~uns & lane_h[15]}}, lane_h};
            default: res = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage register + writeback mux + retire counter; WB_LOAD_EXT_EN enables sub-word load extraction.
// Latency: 1 cycle inputs -> rf_*; rf_* combinational from stage regs.
// Backpressure: stall holds the stage and blocks write/retire; flush (wins over stall) inserts a bubble.
module mem_wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_o,
    input  logic [DATA_W-1:0] dmem_d,
    input  logic [31:0]       insn,
    input  logic [DATA_W-1:0] pc,
    input  logic              rwe,
    input  logic [1:0]        rdst,
    input  logic [1:0]        rwd,
    input  logic [1:0]        ld_size,
    input  logic              ld_uns,
    output logic              wb_valid,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              valid_q;
    logic              rwe_q;
    logic [4:0]        rt_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] dmem_q;
    logic [DATA_W-1:0] pc_q;
    logic [1:0]        rdst_q;
    logic [1:0]        rwd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem_res;
    logic [REG_AW-1:0] waddr;

    // Only the register fields of the instruction matter at writeback.
    logic unused_insn;
    assign unused_insn = ^{insn[31:21], insn[10:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rwe_q   <= 1'b0;
            rt_q    <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            dmem_q  <= '0;
            pc_q    <= '0;
            rdst_q  <= '0;
            rwd_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= in_valid;
            rwe_q   <= rwe;
            rt_q    <= insn[20:16];
            rd_q    <= insn[15:11];
            alu_q   <= alu_o;
            dmem_q  <= dmem_d;
            pc_q    <= pc;
            rdst_q  <= rdst;
            rwd_q   <= rwd;
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [1:0] ld_size_q;
    logic       ld_uns_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_size_q <= '0;
            ld_uns_q  <= 1'b0;
        end else if (!flush && !stall) begin
            ld_size_q <= ld_size;
            ld_uns_q  <= ld_uns;
        end
    end

    wb_load_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .word   (dmem_q),
        .offset (alu_q[1:0]),
        .size   (ld_size_q),
        .uns    (ld_uns_q),
        .res    (mem_res)
    );
`else
    logic unused_ld;
    assign unused_ld = ^{ld_size, ld_uns};
    assign mem_res   = dmem_q;
`endif

    // The reserved encoding 11 falls back to rt.
    always_comb begin
        waddr = REG_AW'(rt_q);
        case (rdst_q)
            RDST_RD: waddr = REG_AW'(rd_q);
            RDST_RA: waddr = REG_AW'(REG_RA);
            default: waddr = REG_AW'(rt_q);
        endcase
    end

    always_comb begin
        rf_wdata = alu_q;
        case (rwd_q)
            RWD_MEM:  rf_wdata = mem_res;
            RWD_LINK: rf_wdata = pc_q + DATA_W'(8);
            default:  rf_wdata = alu_q;
        endcase
    end

    // A stalled instruction has not yet left WB, so it neither writes nor retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (valid_q && !stall) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign wb_valid   = valid_q;
    assign rf_waddr   = waddr;
    assign rf_we      = valid_q & rwe_q & (waddr != '0) & ~stall;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage against a transaction-level model of the WB stage.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, stall, flush, rwe, ld_uns;
    logic [31:0] alu_o, dmem_d, insn, pc;
    logic [1:0]  rdst, rwd, ld_size;
    logic        wb_valid, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, retire_cnt;
    logic        w4_valid, w4_we;
    logic [4:0]  w4_waddr;
    logic [31:0] w4_wdata;
    logic [3:0]  w4_cnt;
    logic [31:0] x_word, x_res;
    logic [1:0]  x_off, x_size;
    logic        x_uns;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic        rwe;
        logic [31:0] insn, alu, dmem, pc;
        logic [1:0]  rdst, rwd, lsz;
        logic        luns;
    } txn_t;

    txn_t        m;
    logic [31:0] mcnt;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_o(alu_o), .dmem_d(dmem_d), .insn(insn), .pc(pc), .rwe(rwe), .rdst(rdst),
        .rwd(rwd), .ld_size(ld_size), .ld_uns(ld_uns), .wb_valid(wb_valid), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_cnt(retire_cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_o(alu_o), .dmem_d(dmem_d), .insn(insn), .pc(pc), .rwe(rwe), .rdst(rdst),
        .rwd(rwd), .ld_size(ld_size), .ld_uns(ld_uns), .wb_valid(w4_valid), .rf_we(w4_we),
        .rf_waddr(w4_waddr), .rf_wdata(w4_wdata), .retire_cnt(w4_cnt)
    );

    wb_load_extract u_lx (
        .word(x_word), .offset(x_off), .size(x_size), .uns(x_uns), .res(x_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_ld(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = a[1] ? (w & 32'hFFFF) : (w >> 16);
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [4:0] exp_waddr();
        if (m.rdst == 2'b01) return m.insn[15:11];
        if (m.rdst == 2'b10) return 5'd31;
        return m.insn[20:16];
    endfunction

    function automatic logic [31:0] exp_wdata();
        if (m.rwd == 2'b01) begin
`ifdef WB_LOAD_EXT_EN
            return exp_ld(m.dmem, m.alu, m.lsz, m.luns);
`else
            return m.dmem;
`endif
        end
        if (m.rwd == 2'b10) return m.pc + 32'd8;
        return m.alu;
    endfunction

    function automatic logic exp_we();
        return m.v && m.rwe && (exp_waddr() != 5'd0) && !stall;
    endfunction

    task automatic model_reset();
        m    = '0;
        mcnt = 32'd0;
    endtask

    // Advance one clock; inputs are already applied. Returns just after the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (m.v && !stall) mcnt = mcnt + 32'd1;
        if (flush) m.v = 1'b0;
        else if (!stall) m = '{in_valid, rwe, insn, alu_o, dmem_d, pc, rdst, rwd, ld_size, ld_uns};
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        in_valid = 1'($urandom);
        rwe      = 1'($urandom);
        alu_o    = $urandom;
        dmem_d   = $urandom;
        insn     = $urandom;
        pc       = $urandom;
        rdst     = 2'($urandom);
        rwd      = 2'($urandom);
        ld_size  = 2'($urandom);
        ld_uns   = 1'($urandom);
    endtask

    task automatic set_insn(input logic [1:0] ds, input logic [1:0] ws, input logic [4:0] rt,
                            input logic [4:0] rd);
        in_valid = 1'b1;
        rwe      = 1'b1;
        rdst     = ds;
        rwd      = ws;
        insn     = {6'h00, 5'd1, rt, rd, 11'h020};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", wb_valid); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
        checks++; if (w4_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt4 got %0d want 0", w4_cnt); end
    endtask

    task automatic test_add();
        logic [31:0] c0;
        set_insn(2'b01, 2'b00, 5'd2, 5'd9);
        alu_o = 32'h1234;
        tick();
        in_valid = 1'b0;
        c0 = retire_cnt;
        #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL add_we got %b want 1", rf_we); end
        checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL add_waddr got %0d want 9", rf_waddr); end
        checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL add_wdata got %h want 1234", rf_wdata); end
        tick();
        checks++; if (retire_cnt !== c0 + 32'd1) begin errors++; $display("FAIL add_cnt got %0d want %0d", retire_cnt, c0 + 32'd1); end
    endtask

    task automatic test_load_extract();
        logic [31:0] want [6];
        logic [1:0]  offs [6];
        logic [1:0]  szs  [6];
        logic        us   [6];
        want = '{32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0000_007F, 32'h0000_0001, 32'h0000_0080, 32'h0000_7F01};
        offs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
        szs  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        us   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        x_word = 32'h80FF_7F01;
        for (int i = 0; i < 6; i++) begin
            x_off = offs[i]; x_size = szs[i]; x_uns = us[i];
            #1;
            checks++; if (x_res !== want[i]) begin errors++; $display("FAIL lx_vec%0d got %h want %h", i, x_res, want[i]); end
        end
        for (int i = 0; i < 40; i++) begin
            x_word = $urandom; x_off = 2'($urandom); x_size = 2'($urandom); x_uns = 1'($urandom);
            #1;
            checks++;
            if (x_res !== exp_ld(x_word, {30'd0, x_off}, x_size, x_uns)) begin
                errors++; $display("FAIL lx_rand got %h want %h", x_res, exp_ld(x_word, {30'd0, x_off}, x_size, x_uns));
            end
        end
        // Same loads through the stage (result depends on build configuration).
        for (int i = 0; i < 6; i++) begin
            set_insn(2'b00, 2'b01, 5'd5, 5'd0);
            dmem_d = 32'h80FF_7F01; alu_o = {30'h0000_0400, offs[i]};
            ld_size = szs[i]; ld_uns = us[i];
            tick();
            #1;
            checks++; if (rf_wdata !== exp_wdata()) begin errors++; $display("FAIL stage_load%0d got %h want %h", i, rf_wdata, exp_wdata()); end
        end
    endtask

    task automatic test_jal();
        set_insn(2'b10, 2'b10, 5'd0, 5'd0);
        pc = 32'h0040_0010;
        tick();
        #1;
        checks++; if (rf_waddr !== 5'd31) begin errors++; $display("FAIL jal_waddr got %0d want 31", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0040_0018) begin errors++; $display("FAIL jal_wdata got %h want 00400018", rf_wdata); end
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL jal_we got %b want 1", rf_we); end
    endtask

    task automatic test_stall();
        logic [4:0]  wa;
        logic [31:0] wd, c0;
        set_insn(2'b01, 2'b00, 5'd3, 5'd12);
        alu_o = $urandom;
        tick();
        wa = 5'd12; wd = alu_o; c0 = mcnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            #1;
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL stall_we got %b want 0", rf_we); end
            checks++; if (rf_waddr !== wa || rf_wdata !== wd) begin errors++; $display("FAIL stall_hold got %0d/%h want %0d/%h", rf_waddr, rf_wdata, wa, wd); end
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", wb_valid); end
            tick();
            checks++; if (retire_cnt !== c0) begin errors++; $display("FAIL stall_cnt got %0d want %0d", retire_cnt, c0); end
        end
        flush = 1'b1;
        tick();
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flushstall_valid got %b want 0", wb_valid); end
        checks++; if (retire_cnt !== c0) begin errors++; $display("FAIL flushstall_cnt got %0d want %0d", retire_cnt, c0); end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_r0();
        set_insn(2'b00, 2'b00, 5'd0, 5'd7);
        tick();
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got %b want 0", rf_we); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL r0_valid got %b want 1", wb_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            #1;
            checks++;
            if (wb_valid !== m.v || rf_we !== exp_we() || rf_waddr !== exp_waddr() ||
                rf_wdata !== exp_wdata() || retire_cnt !== mcnt || w4_cnt !== mcnt[3:0]) begin
                errors++;
                $display("FAIL rand%0d got v%b we%b a%0d d%h c%0d c4 %0d want v%b we%b a%0d d%h c%0d",
                         i, wb_valid, rf_we, rf_waddr, rf_wdata, retire_cnt, w4_cnt,
                         m.v, exp_we(), exp_waddr(), exp_wdata(), mcnt);
            end
            tick();
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_insn(2'b01, 2'b00, 5'd1, 5'd4);
        for (int i = 0; i < 18; i++) begin
            tick();
            #1;
            checks++; if (w4_cnt !== mcnt[3:0]) begin errors++; $display("FAIL wrap_cnt4 got %0d want %0d", w4_cnt, mcnt[3:0]); end
        end
        checks++; if (mcnt != 32'd17 || w4_cnt !== 4'd1) begin errors++; $display("FAIL wrap_final got %0d want 1", w4_cnt); end
    endtask

    task automatic test_reset_mid();
        set_insn(2'b01, 2'b00, 5'd1, 5'd6);
        tick();
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", wb_valid); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_we got %b want 0", rf_we); end
        checks++; if (retire_cnt !== 32'd0 || w4_cnt !== 4'd0) begin errors++; $display("FAIL rmid_cnt got %0d/%0d want 0", retire_cnt, w4_cnt); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; rwe = 1'b0; ld_uns = 1'b0;
        alu_o = '0; dmem_d = '0; insn = '0; pc = '0; rdst = '0; rwd = '0; ld_size = '0;
        x_word = '0; x_off = '0; x_size = '0; x_uns = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_add();
        test_load_extract();
        test_jal();
        test_stall();
        test_r0();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
